// File: rtl/descramble_seq.sv
// Frame-level sequencer: loads the face ROI into the face buffer, then walks the
// frame in raster order, copying plain pixels and unscrambling ROI pixels.
module descramble_seq #(
  parameter int IMG_LOG2 = 8,
  parameter int ROI_LOG2 = 6,
  parameter int ROI_ROW0 = 97,
  parameter int ROI_COL0 = 86,
  parameter int DS_LAT   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  src_rd_en,
  output logic [2*IMG_LOG2-1:0] src_addr,
  input  logic [7:0]            src_data,
  output logic                  face_we,
  output logic [2*ROI_LOG2-1:0] face_waddr,
  output logic [7:0]            face_wdata,
  output logic [2*ROI_LOG2-1:0] face_raddr,
  input  logic [7:0]            face_rdata,
  output logic [2*ROI_LOG2-1:0] ds_in_addr,
  output logic [15:0]           ds_key,
  output logic                  ds_rst_n,
  input  logic [2*ROI_LOG2-1:0] ds_out_addr,
  output logic                  dst_we,
  output logic [2*IMG_LOG2-1:0] dst_addr,
  output logic [7:0]            dst_data
);

  localparam int FW  = 2 * ROI_LOG2;
  localparam int FW1 = FW + 1;
  localparam int WW  = $clog2(DS_LAT + 1);

  localparam logic [IMG_LOG2-1:0] ROW0     = IMG_LOG2'(ROI_ROW0);
  localparam logic [IMG_LOG2-1:0] COL0     = IMG_LOG2'(ROI_COL0);
  localparam logic [IMG_LOG2-1:0] ROW_LAST = IMG_LOG2'(ROI_ROW0 + (1 << ROI_LOG2) - 1);
  localparam logic [IMG_LOG2-1:0] COL_LAST = IMG_LOG2'(ROI_COL0 + (1 << ROI_LOG2) - 1);
  localparam logic [FW:0]         FACE_LAST = FW1'((1 << FW) - 1);
  localparam logic [WW-1:0]       WAIT_INIT = WW'(DS_LAT);

  typedef enum logic [3:0] {
    IDLE, LD_RD, LD_WR, SC_DEC, CP_WR, DS_RST, DS_WAIT, FC_RD, FC_WR, FIN
  } state_e;

  state_e              state_q, state_d;
  logic [IMG_LOG2-1:0] row_q, row_d;
  logic [IMG_LOG2-1:0] col_q, col_d;
  logic [FW:0]         face_q, face_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [15:0]         key_q, key_d;
  logic [FW-1:0]       ds_in_q, ds_in_d;

  logic                  in_roi;
  logic                  last_pix;
  logic                  advance;
  logic [2*IMG_LOG2-1:0] pix;
  logic [2*IMG_LOG2-1:0] load_addr;

  assign in_roi   = (row_q >= ROW0) && (row_q <= ROW_LAST) &&
                    (col_q >= COL0) && (col_q <= COL_LAST);
  assign last_pix = (&row_q) && (&col_q);
  assign pix      = {row_q, col_q};
  // During LOAD the face index itself supplies the ROI-relative row and column.
  assign load_addr = {ROW0 + IMG_LOG2'(face_q[FW-1:ROI_LOG2]),
                      COL0 + IMG_LOG2'(face_q[ROI_LOG2-1:0])};

  assign ds_key     = key_q;
  assign ds_in_addr = ds_in_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    face_d     = face_q;
    wait_d     = wait_q;
    key_d      = key_q;
    ds_in_d    = ds_in_q;
    advance    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    src_rd_en  = 1'b0;
    src_addr   = '0;
    face_we    = 1'b0;
    face_waddr = '0;
    face_wdata = '0;
    face_raddr = '0;
    ds_rst_n   = 1'b1;
    dst_we     = 1'b0;
    dst_addr   = '0;
    dst_data   = '0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          key_d   = key_in;
          row_d   = '0;
          col_d   = '0;
          face_d  = '0;
          state_d = LD_RD;
        end
      end
      LD_RD: begin
        src_rd_en = 1'b1;
        src_addr  = load_addr;
        state_d   = LD_WR;
      end
      LD_WR: begin
        face_we    = 1'b1;
        face_waddr = face_q[FW-1:0];
        face_wdata = src_data;
        if (face_q == FACE_LAST) begin
          face_d  = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = SC_DEC;
        end else begin
          face_d  = face_q + 1'b1;
          state_d = LD_RD;
        end
      end
      SC_DEC: begin
        if (in_roi) begin
          ds_in_d = face_q[FW-1:0];
          state_d = DS_RST;
        end else begin
          src_rd_en = 1'b1;
          src_addr  = pix;
          state_d   = CP_WR;
        end
      end
      CP_WR: begin
        dst_we   = 1'b1;
        dst_addr = pix;
        dst_data = src_data;
        advance  = 1'b1;
      end
      DS_RST: begin
        ds_rst_n = 1'b0;
        wait_d   = WAIT_INIT;
        state_d  = DS_WAIT;
      end
      DS_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WW'(1)) state_d = FC_RD;
      end
      FC_RD: begin
        face_raddr = ds_out_addr;
        state_d    = FC_WR;
      end
      FC_WR: begin
        dst_we   = 1'b1;
        dst_addr = pix;
        dst_data = face_rdata;
        face_d   = face_q + 1'b1;
        advance  = 1'b1;
      end
      FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (last_pix) begin
        state_d = FIN;
      end else begin
        state_d = SC_DEC;
        col_d   = col_q + 1'b1;
        if (&col_q) row_d = row_q + 1'b1;
      end
    end
  end

  // NOTE: reset is synchronous -- it only takes effect at a rising clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      face_q  <= '0;
      wait_q  <= '0;
      key_q   <= '0;
      ds_in_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      face_q  <= face_d;
      wait_q  <= wait_d;
      key_q   <= key_d;
      ds_in_q <= ds_in_d;
    end
  end

endmodule
